// File: rtl/cc_matrixscan_pkg.sv
// cc_matrixscan_pkg
//   Shared definitions for the matrix scanner: the 2-bit FSM state encoding
//   and the default matrix dimensions.
//   No ports.
package cc_matrixscan_pkg;

   localparam int unsigned DefaultRows = 8;
   localparam int unsigned DefaultCols = 8;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StLoad = 2'd1,
      StScan = 2'd2,
      StDone = 2'd3
   } scanState_e;

endpackage

// File: rtl/cc_matrixscan_rowcheck.sv
// cc_matrixscan_rowcheck
//   Combinational check of one matrix row.
//   Build option: CC_MATRIXSCAN_HITCOUNT_EN adds the popCount output.
//   Ports:
//     playerRow   in  COLS  player bits of the row
//     obstacleRow in  COLS  obstacle bits of the row
//     overlap     out 1     any bit set in both rows
//     nonzero     out 1     any player bit set
//     popCount    out       number of overlapping bits (option only)
module cc_matrixscan_rowcheck
   import cc_matrixscan_pkg::*;
#(
   parameter int unsigned COLS = DefaultCols
) (
   input  logic [COLS-1:0] playerRow,
   input  logic [COLS-1:0] obstacleRow,
   output logic            overlap,
   output logic            nonzero
`ifdef CC_MATRIXSCAN_HITCOUNT_EN
   ,
   output logic [$clog2(COLS+1)-1:0] popCount
`endif
);

   logic [COLS-1:0] hits;

   assign hits    = playerRow & obstacleRow;
   assign overlap = |hits;
   assign nonzero = |playerRow;

`ifdef CC_MATRIXSCAN_HITCOUNT_EN
   localparam int unsigned PopW = $clog2(COLS + 1);

   always_comb begin
      popCount = '0;
      for (int i = 0; i < int'(COLS); i++) begin
         popCount = popCount + PopW'(hits[i]);
      end
   end
`endif

endmodule

// File: rtl/cc_matrix_scanner.sv
// cc_matrix_scanner
//   Snapshots a player matrix and an obstacle matrix on request, then scans
//   them one row per cycle to report crash / empty / win results.
//   Build option: CC_MATRIXSCAN_HITCOUNT_EN adds a total overlap-bit count.
//   Ports:
//     CC_MATRIXSCAN_CLOCK_50        in  1          clock (rising edge)
//     CC_MATRIXSCAN_RESET_InHigh    in  1          synchronous reset, active high
//     CC_MATRIXSCAN_start_InHigh    in  1          scan request, honoured in IDLE
//     CC_MATRIXSCAN_player_InBUS    in  ROWS*COLS  player matrix, row r at [r*COLS +: COLS]
//     CC_MATRIXSCAN_obstacle_InBUS  in  ROWS*COLS  obstacle matrix, same packing
//     CC_MATRIXSCAN_busy_OutHigh    out 1          high while loading or scanning
//     CC_MATRIXSCAN_done_OutHigh    out 1          one-cycle pulse when results update
//     CC_MATRIXSCAN_crash_OutHigh   out 1          player overlaps an obstacle
//     CC_MATRIXSCAN_empty_OutHigh   out 1          player matrix all zero
//     CC_MATRIXSCAN_win_OutHigh     out 1          player in last row, no crash
//     CC_MATRIXSCAN_hitcount_OutBUS out            overlapping bit total (option only)
module cc_matrix_scanner
   import cc_matrixscan_pkg::*;
#(
   parameter int unsigned MATRIXSCAN_ROWS = DefaultRows,
   parameter int unsigned MATRIXSCAN_COLS = DefaultCols
) (
   input  logic                                       CC_MATRIXSCAN_CLOCK_50,
   input  logic                                       CC_MATRIXSCAN_RESET_InHigh,
   input  logic                                       CC_MATRIXSCAN_start_InHigh,
   input  logic [MATRIXSCAN_ROWS*MATRIXSCAN_COLS-1:0] CC_MATRIXSCAN_player_InBUS,
   input  logic [MATRIXSCAN_ROWS*MATRIXSCAN_COLS-1:0] CC_MATRIXSCAN_obstacle_InBUS,
   output logic                                       CC_MATRIXSCAN_busy_OutHigh,
   output logic                                       CC_MATRIXSCAN_done_OutHigh,
   output logic                                       CC_MATRIXSCAN_crash_OutHigh,
   output logic                                       CC_MATRIXSCAN_empty_OutHigh,
   output logic                                       CC_MATRIXSCAN_win_OutHigh
`ifdef CC_MATRIXSCAN_HITCOUNT_EN
   ,
   output logic [$clog2(MATRIXSCAN_ROWS*MATRIXSCAN_COLS+1)-1:0] CC_MATRIXSCAN_hitcount_OutBUS
`endif
);

   localparam int unsigned Bits = MATRIXSCAN_ROWS * MATRIXSCAN_COLS;
   localparam int unsigned IdxW = $clog2(MATRIXSCAN_ROWS);
   localparam logic [IdxW-1:0] LastRow = IdxW'(MATRIXSCAN_ROWS - 1);

   scanState_e          state;
   logic [IdxW-1:0]     rowIdx;
   logic [Bits-1:0]     playerSnap;
   logic [Bits-1:0]     obstacleSnap;
   logic                crashAcc;
   logic                anyAcc;
   logic                lastAcc;

   logic [MATRIXSCAN_COLS-1:0] playerRow;
   logic [MATRIXSCAN_COLS-1:0] obstacleRow;
   logic                       rowOverlap;
   logic                       rowNonzero;

   assign playerRow   = playerSnap[rowIdx*MATRIXSCAN_COLS +: MATRIXSCAN_COLS];
   assign obstacleRow = obstacleSnap[rowIdx*MATRIXSCAN_COLS +: MATRIXSCAN_COLS];

`ifdef CC_MATRIXSCAN_HITCOUNT_EN
   localparam int unsigned HitW = $clog2(Bits + 1);
   logic [$clog2(MATRIXSCAN_COLS+1)-1:0] rowPop;
   logic [HitW-1:0]                      hitAcc;
`endif

   cc_matrixscan_rowcheck #(
      .COLS (MATRIXSCAN_COLS)
   ) uRowcheck (
      .playerRow   (playerRow),
      .obstacleRow (obstacleRow),
      .overlap     (rowOverlap),
      .nonzero     (rowNonzero)
`ifdef CC_MATRIXSCAN_HITCOUNT_EN
      ,
      .popCount    (rowPop)
`endif
   );

   always_ff @(posedge CC_MATRIXSCAN_CLOCK_50) begin
      if (CC_MATRIXSCAN_RESET_InHigh) begin
         state                       <= StIdle;
         rowIdx                      <= '0;
         playerSnap                  <= '0;
         obstacleSnap                <= '0;
         crashAcc                    <= 1'b0;
         anyAcc                      <= 1'b0;
         lastAcc                     <= 1'b0;
         CC_MATRIXSCAN_busy_OutHigh  <= 1'b0;
         CC_MATRIXSCAN_done_OutHigh  <= 1'b0;
         CC_MATRIXSCAN_crash_OutHigh <= 1'b0;
         CC_MATRIXSCAN_empty_OutHigh <= 1'b0;
         CC_MATRIXSCAN_win_OutHigh   <= 1'b0;
`ifdef CC_MATRIXSCAN_HITCOUNT_EN
         hitAcc                        <= '0;
         CC_MATRIXSCAN_hitcount_OutBUS <= '0;
`endif
      end else begin
         CC_MATRIXSCAN_done_OutHigh <= 1'b0;
         case (state)
            StIdle: begin
               if (CC_MATRIXSCAN_start_InHigh) begin
                  state                      <= StLoad;
                  CC_MATRIXSCAN_busy_OutHigh <= 1'b1;
               end
            end
            StLoad: begin
               playerSnap   <= CC_MATRIXSCAN_player_InBUS;
               obstacleSnap <= CC_MATRIXSCAN_obstacle_InBUS;
               rowIdx       <= '0;
               crashAcc     <= 1'b0;
               anyAcc       <= 1'b0;
               lastAcc      <= 1'b0;
`ifdef CC_MATRIXSCAN_HITCOUNT_EN
               hitAcc       <= '0;
`endif
               state        <= StScan;
            end
            StScan: begin
               crashAcc <= crashAcc | rowOverlap;
               anyAcc   <= anyAcc | rowNonzero;
               lastAcc  <= lastAcc | (rowNonzero && (rowIdx == LastRow));
`ifdef CC_MATRIXSCAN_HITCOUNT_EN
               hitAcc   <= hitAcc + HitW'(rowPop);
`endif
               // Index holds at the last row rather than wrapping.
               if (rowIdx == LastRow) begin
                  state                      <= StDone;
                  CC_MATRIXSCAN_busy_OutHigh <= 1'b0;
               end else begin
                  rowIdx <= rowIdx + 1'b1;
               end
            end
            StDone: begin
               // Empty overrides crash, crash overrides win.
               CC_MATRIXSCAN_empty_OutHigh <= ~anyAcc;
               CC_MATRIXSCAN_crash_OutHigh <= anyAcc & crashAcc;
               CC_MATRIXSCAN_win_OutHigh   <= anyAcc & ~crashAcc & lastAcc;
`ifdef CC_MATRIXSCAN_HITCOUNT_EN
               CC_MATRIXSCAN_hitcount_OutBUS <= hitAcc;
`endif
               CC_MATRIXSCAN_done_OutHigh  <= 1'b1;
               state                       <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule
